// File: rtl/serial_pattern_tx_if.sv
// rtl/serial_pattern_tx_if.sv - word handshake into the serial pattern transmitter
interface serial_pattern_tx_if #(
   parameter int WIDTH = 8,
   parameter int RPT_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data_in;
   logic [RPT_W-1:0] rpt_in;

   modport master (output in_valid, data_in, rpt_in, input in_ready);
   modport slave  (input in_valid, data_in, rpt_in, output in_ready);
endinterface

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - serializes a word MSB-first onto dout, repeated rpt_in+1 times
// with GAP idle cycles between copies; one-hot state is exported for detector-style checks.
module serial_pattern_tx #(
   parameter int WIDTH = 8,
   parameter int GAP   = 2,
   parameter int RPT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   serial_pattern_tx_if.slave in_if,
   output logic               dout,
   output logic               dout_valid,
   output logic               done,
   output logic [3:0]         state
);
   localparam int BW     = $clog2(WIDTH);
   localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_SHIFT = 4'b0010,
      S_GAP   = 4'b0100,
      S_DONE  = 4'b1000
   } state_t;

   state_t           st;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] hold;
   logic [BW-1:0]    bcnt;
   logic [RPT_W-1:0] rcnt;
   logic [3:0]       gcnt;

   assign state          = st;
   assign in_if.in_ready = (st == S_IDLE);

   // dout/dout_valid/done are loaded with the value for the coming cycle at each edge
   always_ff @(posedge clk) begin
      if (rst) begin
         st         <= S_IDLE;
         shreg      <= '0;
         hold       <= '0;
         bcnt       <= '0;
         rcnt       <= '0;
         gcnt       <= '0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (st)
            S_IDLE: begin
               if (in_if.in_valid) begin
                  shreg      <= in_if.data_in;
                  hold       <= in_if.data_in;
                  rcnt       <= in_if.rpt_in;
                  bcnt       <= BW'(WIDTH - 1);
                  dout       <= in_if.data_in[WIDTH-1];
                  dout_valid <= 1'b1;
                  st         <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (bcnt != '0) begin
                  shreg <= shreg << 1;
                  bcnt  <= bcnt - BW'(1);
                  dout  <= shreg[WIDTH-2];
               end else if (rcnt == '0) begin
                  st         <= S_DONE;
                  done       <= 1'b1;
                  dout       <= 1'b0;
                  dout_valid <= 1'b0;
               end else begin
                  rcnt  <= rcnt - RPT_W'(1);
                  shreg <= hold;
                  bcnt  <= BW'(WIDTH - 1);
                  if (GAP > 0) begin
                     st         <= S_GAP;
                     gcnt       <= 4'(GAP_M1);
                     dout       <= 1'b0;
                     dout_valid <= 1'b0;
                  end else begin
                     dout <= hold[WIDTH-1];
                  end
               end
            end
            S_GAP: begin
               if (gcnt == 4'd0) begin
                  st         <= S_SHIFT;
                  dout       <= shreg[WIDTH-1];
                  dout_valid <= 1'b1;
               end else begin
                  gcnt <= gcnt - 4'd1;
               end
            end
            S_DONE: begin
               st <= S_IDLE;
            end
            default: begin
               st         <= S_IDLE;
               dout       <= 1'b0;
               dout_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - randomized bench for serial_pattern_tx against a cycle-list model
module tb_serial_pattern_tx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   serial_pattern_tx_if #(.WIDTH(8), .RPT_W(4)) if0 ();
   serial_pattern_tx_if #(.WIDTH(8), .RPT_W(4)) if1 ();

   logic       dout0, dv0, done0;
   logic [3:0] st0;
   logic       dout1, dv1, done1;
   logic [3:0] st1;

   serial_pattern_tx #(.WIDTH(8), .GAP(2), .RPT_W(4)) dut0 (
      .clk(clk), .rst(rst), .in_if(if0.slave),
      .dout(dout0), .dout_valid(dv0), .done(done0), .state(st0)
   );

   serial_pattern_tx #(.WIDTH(8), .GAP(0), .RPT_W(4)) dut1 (
      .clk(clk), .rst(rst), .in_if(if1.slave),
      .dout(dout1), .dout_valid(dv1), .done(done1), .state(st1)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int d, input logic v, input logic [7:0] w, input logic [3:0] r);
      if (d == 0) begin
         if0.in_valid = v; if0.data_in = w; if0.rpt_in = r;
      end else begin
         if1.in_valid = v; if1.data_in = w; if1.rpt_in = r;
      end
   endtask

   // {in_ready, done, dout_valid, dout, state}
   function automatic logic [7:0] snap(input int d);
      if (d == 0) return {if0.in_ready, done0, dv0, dout0, st0};
      return {if1.in_ready, done1, dv1, dout1, st1};
   endfunction

   function automatic int gap_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   logic rst_q = 1'b1;
   always @(posedge clk) rst_q <= rst;

   always @(negedge clk) begin
      check("onehot0", 32'($onehot(st0)), 32'd1);
      check("onehot1", 32'($onehot(st1)), 32'd1);
      if (rst_q) begin
         check("rst_idle0", 32'(st0), 32'd1);
         check("rst_idle1", 32'(st1), 32'd1);
      end
   end

   // Called at a negedge; returns at the negedge where in_ready is back high.
   task automatic run_word(input int d, input logic [7:0] w, input logic [3:0] r, input bit noise);
      logic [7:0] q[$];
      logic [7:0] s;
      int budget;
      budget = 0;
      s = snap(d);
      while (s[7] !== 1'b1 && budget < 300) begin
         @(negedge clk);
         budget++;
         s = snap(d);
      end
      check($sformatf("ready d%0d w%02h", d, w), 32'(s[7]), 32'd1);
      for (int k = 0; k <= int'(r); k++) begin
         for (int b = 7; b >= 0; b--) q.push_back({3'b001, w[b], 4'b0010});
         if (k < int'(r))
            for (int g = 0; g < gap_of(d); g++) q.push_back(8'b0000_0100);
      end
      q.push_back(8'b0100_1000);
      q.push_back(8'b1000_0001);
      drive(d, 1'b1, w, r);
      @(posedge clk);
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         check($sformatf("d%0d w%02h r%0d c%0d", d, w, r, i + 1), 32'(snap(d)), 32'(q[i]));
         if (noise && i < q.size() - 2) drive(d, 1'b1, 8'($urandom), 4'($urandom));
         else drive(d, 1'b0, 8'h00, 4'h0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      drive(0, 1'b0, 8'h00, 4'h0);
      drive(1, 1'b0, 8'h00, 4'h0);
      repeat (3) @(negedge clk);
      check("reset0", 32'(snap(0)), 32'h81);
      check("reset1", 32'(snap(1)), 32'h81);
      rst = 1'b0;

      run_word(0, 8'b1011_0011, 4'd0, 1'b0);
      run_word(0, 8'hA5, 4'd2, 1'b0);
      run_word(1, 8'hFF, 4'd1, 1'b0);

      // reset lands while bit 4 is on the line; handshake offered during reset must be ignored
      drive(0, 1'b1, 8'h3C, 4'd1);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 8'h00, 4'h0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      drive(0, 1'b1, 8'($urandom), 4'($urandom));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("midrst c%0d", i), 32'(snap(0)), 32'h81);
      end
      rst = 1'b0;
      drive(0, 1'b0, 8'h00, 4'h0);
      run_word(0, 8'h96, 4'd0, 1'b0);

      run_word(0, 8'($urandom), 4'd15, 1'b1);
      run_word(1, 8'($urandom), 4'd15, 1'b0);

      for (int n = 0; n < 14; n++) begin
         run_word(int'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, 3)),
                  bit'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
